// File: rtl/i2c_seg_pkg.sv
// Shared definitions for the I2C 7-segment target: FSM states, register map,
// control bit positions and the hex-to-segment table.
package i2c_seg_pkg;

    // Ordering matters: every state from ST_ADDR_ACK upward counts as busy.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_IGNORE    = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_PTR       = 4'd4,
        ST_PTR_ACK   = 4'd5,
        ST_WDATA     = 4'd6,
        ST_WDATA_ACK = 4'd7,
        ST_RDATA     = 4'd8,
        ST_RDATA_ACK = 4'd9
    } state_e;

    localparam int REG_RAW     = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_HEX     = 2;
    localparam int REG_SCRATCH = 3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_HEX = 1;

    // {g,f,e,d,c,b,a} patterns, entry 15 first down to entry 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic is_busy(input state_e s);
        return (s >= ST_ADDR_ACK);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-high {g..a} segment pattern.
module seg_hex_decode
    import i2c_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_digit];

endmodule

// File: rtl/i2c_seg_target.sv
// I2C target with a small register file that selects the raw or hex-decoded
// pattern driven onto the 7-segment outputs.
module i2c_seg_target
    import i2c_seg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int         NUM_REGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] seg_out,
    output logic       reg_wr,
    output logic       busy
);

    localparam int PTR_W = $clog2(NUM_REGS);

    logic             r_scl_meta, r_scl_sync, r_scl_prev;
    logic             r_sda_meta, r_sda_sync, r_sda_prev;
    logic             w_scl_rise, w_scl_fall, w_start, w_stop;
    state_e           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt, w_byte, w_rd_byte;
    logic             r_sda_oe, w_oe_nxt, r_rw, w_rw_nxt, w_commit;
    logic             r_reg_wr, r_busy;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]       r_regs [NUM_REGS];
    logic [6:0]       w_hex_seg;
    logic [7:0]       r_seg, w_seg_nxt;

    // Synchronizers reset to SCL high / SDA low so leaving reset can never look like a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b0;
            r_sda_sync <= 1'b0;
            r_sda_prev <= 1'b0;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    assign w_byte     = {r_shift[6:0], r_sda_sync};
    assign w_rd_byte  = r_regs[r_ptr];

    // Bus protocol next-state: sample on SCL rise, drive SDA on SCL fall.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_oe_nxt    = r_sda_oe;
        w_ptr_nxt   = r_ptr;
        w_rw_nxt    = r_rw;
        w_commit    = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    w_shift_nxt = w_byte;
                    if (r_cnt == 4'd7) begin
                        w_cnt_nxt = 4'd0;
                        case (r_state)
                            ST_ADDR: begin
                                w_rw_nxt    = w_byte[0];
                                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                            end
                            ST_PTR: begin
                                w_ptr_nxt   = w_byte[PTR_W-1:0];
                                w_state_nxt = ST_PTR_ACK;
                            end
                            default: begin
                                w_commit    = 1'b1;
                                w_ptr_nxt   = r_ptr + PTR_W'(1);
                                w_state_nxt = ST_WDATA_ACK;
                            end
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                ST_RDATA:     w_cnt_nxt = r_cnt + 4'd1;
                ST_RDATA_ACK: w_state_nxt = r_sda_sync ? ST_IGNORE : ST_RDATA_ACK;
                default:      w_cnt_nxt = r_cnt;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (r_cnt == 4'd0) begin
                        w_oe_nxt  = 1'b1;
                        w_cnt_nxt = 4'd1;
                    end else begin
                        w_cnt_nxt = 4'd0;
                        w_oe_nxt  = 1'b0;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                            w_shift_nxt = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                            w_state_nxt = ST_RDATA;
                        end else if (r_state == ST_ADDR_ACK) begin
                            w_state_nxt = ST_PTR;
                        end else begin
                            w_state_nxt = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (r_cnt == 4'd8) begin
                        w_oe_nxt    = 1'b0;
                        w_ptr_nxt   = r_ptr + PTR_W'(1);
                        w_state_nxt = ST_RDATA_ACK;
                    end else begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_oe_nxt    = ~r_shift[6];
                    end
                end
                ST_RDATA_ACK: begin
                    w_shift_nxt = w_rd_byte;
                    w_oe_nxt    = ~w_rd_byte[7];
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_RDATA;
                end
                default: w_oe_nxt = r_sda_oe;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Protocol state, shifter, pointer and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_shift  <= 8'h00;
            r_sda_oe <= 1'b0;
            r_ptr    <= '0;
            r_rw     <= 1'b0;
            r_reg_wr <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_sda_oe <= w_oe_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rw     <= w_rw_nxt;
            r_reg_wr <= w_commit;
            r_busy   <= is_busy(w_state_nxt);
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_commit) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    seg_hex_decode u_hex (
        .i_digit (r_regs[REG_HEX][3:0]),
        .o_seg   (w_hex_seg)
    );

    // Display source selection.
    always_comb begin
        if (!r_regs[REG_CTRL][CTRL_EN]) begin
            w_seg_nxt = 8'h00;
        end else if (r_regs[REG_CTRL][CTRL_HEX]) begin
            w_seg_nxt = {r_regs[REG_HEX][4], w_hex_seg};
        end else begin
            w_seg_nxt = r_regs[REG_RAW];
        end
    end

    // Registered segment drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 8'h00;
        end else begin
            r_seg <= w_seg_nxt;
        end
    end

    assign sda_oe  = r_sda_oe;
    assign seg_out = r_seg;
    assign reg_wr  = r_reg_wr;
    assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_seg_target.sv
// Randomized bench for i2c_seg_target: drives an open-drain I2C bus and checks
// acks, read data, write pulses and the display against a register-file model.
module tb_i2c_seg_target;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n, scl, m_sda, w_sda;
    logic       sda_oe, reg_wr, busy;
    logic [7:0] seg_out;

    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0;
    logic       oe_seen = 1'b0;

    logic [7:0] m_regs [4];
    int         m_ptr = 0;
    logic [7:0] wbuf [4];
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    assign w_sda = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_seg_target #(.DEV_ADDR(7'h2A), .NUM_REGS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (w_sda),
        .sda_oe  (sda_oe),
        .seg_out (seg_out),
        .reg_wr  (reg_wr),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (reg_wr) wr_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg();
        if (!m_regs[1][0]) return 8'h00;
        if (m_regs[1][1]) return {m_regs[2][4], hex_tab[m_regs[2][3:0]]};
        return m_regs[0];
    endfunction

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hq(); scl = 1'b1; hq(); m_sda = 1'b0; hq(); scl = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hq(); scl = 1'b1; hq(); m_sda = 1'b1; hq(); hq();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; hq(); scl = 1'b1; hq(); b = w_sda; hq(); scl = 1'b0; hq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        send_bit(nack);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] ptr, input int n);
        logic ack, good;
        int   wr0;
        good = (addr == 7'h2A);
        wr0 = wr_cnt;
        oe_seen = 1'b0;
        i2c_start();
        write_byte({addr, 1'b0}, ack);
        check_eq("addr_ack", 32'(ack), 32'(!good));
        check_eq("busy_mid", 32'(busy), 32'(good));
        write_byte(ptr, ack);
        check_eq("ptr_ack", 32'(ack), 32'(!good));
        if (good) m_ptr = int'(ptr) % 4;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check_eq("data_ack", 32'(ack), 32'(!good));
            if (good) begin
                m_regs[m_ptr] = wbuf[i];
                m_ptr = (m_ptr + 1) % 4;
            end
        end
        i2c_stop();
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("wr_count", 32'(wr_cnt - wr0), 32'(good ? n : 0));
        check_eq("seg_out", 32'(seg_out), 32'(exp_seg()));
        if (!good) check_eq("oe_quiet", 32'(oe_seen), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        write_byte({7'h2A, 1'b0}, ack);
        check_eq("rd_waddr_ack", 32'(ack), 32'd0);
        write_byte(ptr, ack);
        check_eq("rd_ptr_ack", 32'(ack), 32'd0);
        m_ptr = int'(ptr) % 4;
        i2c_start();
        write_byte({7'h2A, 1'b1}, ack);
        check_eq("rd_raddr_ack", 32'(ack), 32'd0);
        check_eq("busy_rd", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, (i == n - 1));
            check_eq("rdata", 32'(b), 32'(m_regs[m_ptr]));
            m_ptr = (m_ptr + 1) % 4;
        end
        hq();
        check_eq("oe_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        check_eq("busy_rd_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic ack;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_seg", 32'(seg_out), 32'd0);
        check_eq("rst_wr", 32'(reg_wr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        wbuf[0] = 8'h7F; wbuf[1] = 8'h01;
        do_write(7'h2A, 8'h00, 2);
        check_eq("tp_basic", 32'(seg_out), 32'h7F);
        wbuf[0] = 8'h03; wbuf[1] = 8'h15;
        do_write(7'h2A, 8'h01, 2);
        check_eq("tp_hex5", 32'(seg_out), 32'hED);
        wbuf[0] = 8'h0A;
        do_write(7'h2A, 8'h02, 1);
        check_eq("tp_hexA", 32'(seg_out), 32'h77);
        wbuf[0] = 8'hAA; wbuf[1] = 8'h11;
        do_write(7'h2A, 8'h03, 2);
        do_read(8'h03, 2);
        wbuf[0] = 8'h99; wbuf[1] = 8'h98; wbuf[2] = 8'h97;
        do_write(7'h2B, 8'h00, 3);
        do_read(8'h00, 4);
        wbuf[0] = 8'h33;
        do_write(7'h2A, 8'h06, 1);
        do_read(8'h00, 4);

        // Reset in the middle of a data byte with the display enabled.
        wbuf[0] = 8'h5A; wbuf[1] = 8'h01;
        do_write(7'h2A, 8'h00, 2);
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h00, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_oe", 32'(sda_oe), 32'd0);
        check_eq("midrst_seg", 32'(seg_out), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        hq();
        rst_n = 1'b1;
        oe_seen = 1'b0;
        begin
            int wr0;
            wr0 = wr_cnt;
            for (int i = 0; i < 4; i++) send_bit(1'b0);
            recv_bit(ack);
            check_eq("postrst_ack", 32'(ack), 32'd1);
            write_byte(8'h01, ack);
            check_eq("postrst_ack2", 32'(ack), 32'd1);
            i2c_stop();
            check_eq("postrst_oe", 32'(oe_seen), 32'd0);
            check_eq("postrst_wr", 32'(wr_cnt - wr0), 32'd0);
            check_eq("postrst_seg", 32'(seg_out), 32'd0);
        end
        wbuf[0] = 8'h3C; wbuf[1] = 8'h01;
        do_write(7'h2A, 8'h00, 2);
        check_eq("postrst_txn", 32'(seg_out), 32'h3C);

        for (int it = 0; it < 18; it++) begin
            logic [6:0] a;
            int         n;
            a = 7'h2A;
            if ($urandom_range(0, 5) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h2A) a = 7'h2B;
            end
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
            do_write(a, 8'($urandom), n);
            do_read(8'($urandom), int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
